// File: rtl/eq_band_mixer.sv
// eq_band_mixer: per-sample gain-and-sum stage behind the equalizer FIR bank.
// Captures all band outputs and band gains on a sample strobe. It then
// multiply-accumulates them one band per cycle on a single shared multiplier.
// The sum is scaled by 1/64 and saturated to 24-bit signed audio.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   in_valid  - one-cycle sample strobe
//   bands_in  - NB x 24-bit signed band samples, band k at [24k+23:24k]
//   gains_in  - NB x GAIN_W-bit unsigned Q2.6 gains, band k at [GAIN_W*k +: GAIN_W]
//   audio_out - registered saturated mix, holds between updates
//   out_valid - one-cycle pulse when audio_out updates
//   clip      - registered with audio_out, 1 iff that sample saturated
//   busy      - high whenever the FSM is not idle (decoded from state)
//   overrun   - sticky, strobe arrived while busy; cleared only by rst
module eq_band_mixer #(
  parameter int unsigned NB     = 3,
  parameter int unsigned GAIN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [24*NB-1:0]       bands_in,
  input  logic [GAIN_W*NB-1:0]   gains_in,
  output logic [23:0]            audio_out,
  output logic                   out_valid,
  output logic                   clip,
  output logic                   busy,
  output logic                   overrun
);

  localparam int unsigned SAMP_W = 24;
  localparam int unsigned PROD_W = SAMP_W + GAIN_W + 1;
  localparam int unsigned ACC_W  = PROD_W + $clog2(NB);
  localparam int unsigned IDX_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned SHIFT  = 6;

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NB - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(8388607);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-8388608);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_capture;
  logic                      w_accum;
  logic                      w_emit;

  logic [SAMP_W*NB-1:0]      r_bands;
  logic [GAIN_W*NB-1:0]      r_gains;
  logic signed [ACC_W-1:0]   r_acc;
  logic [IDX_W-1:0]          r_idx;
  logic [SAMP_W-1:0]         r_audio;
  logic                      r_out_valid;
  logic                      r_clip;
  logic                      r_overrun;

  logic [SAMP_W-1:0]         w_band;
  logic [GAIN_W-1:0]         w_gain;
  logic signed [PROD_W-1:0]  w_band_x;
  logic signed [PROD_W-1:0]  w_gain_x;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_res;
  logic                      w_sat_hi;
  logic                      w_sat_lo;
  logic [SAMP_W-1:0]         w_sat;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and datapath control decode
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_accum     = 1'b0;
    w_emit      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        w_accum = 1'b1;
        if (r_idx == LAST_IDX) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        w_emit      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shared multiplier: signed band times zero-extended (never signed) gain
  assign w_band   = r_bands[SAMP_W*r_idx +: SAMP_W];
  assign w_gain   = r_gains[GAIN_W*r_idx +: GAIN_W];
  assign w_band_x = PROD_W'($signed(w_band));
  assign w_gain_x = $signed(PROD_W'(w_gain));
  assign w_prod   = w_band_x * w_gain_x;

  // Q2.6 rescale (floor) and saturation to 24-bit signed
  assign w_res    = r_acc >>> SHIFT;
  assign w_sat_hi = (w_res > SAT_MAX);
  assign w_sat_lo = (w_res < SAT_MIN);
  assign w_sat    = w_sat_hi ? 24'h7F_FFFF :
                    w_sat_lo ? 24'h80_0000 : w_res[SAMP_W-1:0];

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bands     <= '0;
      r_gains     <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_audio     <= '0;
      r_out_valid <= 1'b0;
      r_clip      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (in_valid && (r_state != S_IDLE)) r_overrun <= 1'b1;
      if (w_capture) begin
        r_bands <= bands_in;
        r_gains <= gains_in;
        r_acc   <= '0;
        r_idx   <= '0;
      end
      if (w_accum) begin
        r_acc <= r_acc + ACC_W'(w_prod);
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_emit) begin
        r_audio     <= w_sat;
        r_clip      <= w_sat_hi | w_sat_lo;
        r_out_valid <= 1'b1;
      end
    end
  end

  assign audio_out = r_audio;
  assign out_valid = r_out_valid;
  assign clip      = r_clip;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_eq_band_mixer.sv
// Directed testbench for eq_band_mixer (NB=3, GAIN_W=8).
// Inputs are driven 1 time unit after the rising edge; outputs are checked at
// the same point, away from the active edge.
module tb_eq_band_mixer;

  localparam int unsigned NB     = 3;
  localparam int unsigned GAIN_W = 8;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic [24*NB-1:0]     bands_in;
  logic [GAIN_W*NB-1:0] gains_in;
  logic [23:0]          audio_out;
  logic                 out_valid;
  logic                 clip;
  logic                 busy;
  logic                 overrun;

  int n_vec;
  int n_err;

  eq_band_mixer #(.NB(NB), .GAIN_W(GAIN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .bands_in  (bands_in),
    .gains_in  (gains_in),
    .audio_out (audio_out),
    .out_valid (out_valid),
    .clip      (clip),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Waits up to a bounded number of edges for out_valid; returns edges waited.
  task automatic wait_out(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
  endtask

  // One full sample: strobe, check latency, output, clip and pulse width.
  task automatic run_sample(input string tag, input logic [24*NB-1:0] b,
                            input logic [GAIN_W*NB-1:0] g,
                            input logic [23:0] exp_audio, input logic exp_clip);
    int cnt;
    bands_in = b;
    gains_in = g;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_out(cnt);
    check({tag, "_lat"}, 32'(cnt), 32'(NB + 1));
    check({tag, "_audio"}, 32'(audio_out), 32'(exp_audio));
    check({tag, "_clip"}, 32'(clip), 32'(exp_clip));
    tick();
    check({tag, "_vdrop"}, 32'(out_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int  cnt;
    logic seen;
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    bands_in = '0;
    gains_in = '0;
    tick();
    tick();
    check("rst_audio", 32'(audio_out), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_clip", 32'(clip), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick();

    // Unity gains: 1000 + 2000 - 500
    run_sample("unity", {24'(-500), 24'(2000), 24'(1000)}, {8'd64, 8'd64, 8'd64},
               24'(2500), 1'b0);
    // Mixed gains: 1000*2 + 2000/2 + 0
    run_sample("mixed", {24'(-500), 24'(2000), 24'(1000)}, {8'd0, 8'd32, 8'd128},
               24'(3000), 1'b0);
    // Saturation high and low
    run_sample("sat_hi", {24'(8388607), 24'(8388607), 24'(8388607)},
               {8'd255, 8'd255, 8'd255}, 24'h7F_FFFF, 1'b1);
    run_sample("sat_lo", {24'(-8388608), 24'(-8388608), 24'(-8388608)},
               {8'd255, 8'd255, 8'd255}, 24'h80_0000, 1'b1);
    // Gain 255 must be unsigned: -1 * 255 * 3 / 64 = floor(-11.95) = -12
    run_sample("gain_uns", {24'(-1), 24'(-1), 24'(-1)}, {8'd255, 8'd255, 8'd255},
               24'(-12), 1'b0);
    // Floor truncation
    run_sample("trunc_neg", {24'(777), 24'(555), 24'(-1)}, {8'd0, 8'd0, 8'd1},
               24'(-1), 1'b0);
    run_sample("trunc_pos", {24'(777), 24'(555), 24'(63)}, {8'd0, 8'd0, 8'd1},
               24'(0), 1'b0);
    check("no_ovr_yet", 32'(overrun), 32'd0);

    // Overrun and input hold: strobe at T, bands change at T+1, strobe at T+2
    bands_in = {24'(-500), 24'(2000), 24'(1000)};
    gains_in = {8'd64, 8'd64, 8'd64};
    in_valid = 1'b1;
    tick();                                   // T
    in_valid = 1'b0;
    bands_in = {24'(4000), 24'(4000), 24'(4000)};
    tick();                                   // T+1
    in_valid = 1'b1;
    tick();                                   // T+2
    in_valid = 1'b0;
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_busy", 32'(busy), 32'd1);
    wait_out(cnt);
    check("ovr_lat", 32'(cnt), 32'd2);        // output at T+4
    check("ovr_audio", 32'(audio_out), 32'(24'(2500)));
    // Third strobe sampled at T+5, the minimum spacing
    bands_in = {24'(0), 24'(0), 24'(640)};
    gains_in = {8'd64, 8'd64, 8'd64};
    in_valid = 1'b1;
    tick();                                   // T+5
    in_valid = 1'b0;
    check("ovr_single", 32'(out_valid), 32'd0);
    check("third_busy", 32'(busy), 32'd1);
    wait_out(cnt);
    check("third_lat", 32'(cnt), 32'(NB + 1));
    check("third_audio", 32'(audio_out), 32'(24'(640)));
    check("ovr_hold", 32'(overrun), 32'd1);
    tick();

    // Reset mid-ACCUM: strobe at T, reset asserted at T+2
    bands_in = {24'(1000), 24'(1000), 24'(1000)};
    gains_in = {8'd64, 8'd64, 8'd64};
    in_valid = 1'b1;
    tick();                                   // T
    in_valid = 1'b0;
    tick();                                   // T+1
    tick();                                   // T+2
    rst = 1'b1;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ovr", 32'(overrun), 32'd0);
    check("mrst_audio", 32'(audio_out), 32'd0);
    tick();
    check("mrst_busy2", 32'(busy), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("mrst_nov", 32'(seen), 32'd0);
    check("mrst_audio2", 32'(audio_out), 32'd0);
    check("mrst_clip", 32'(clip), 32'd0);
    check("mrst_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
